// File: rtl/key_expansion_seq_if.sv
// ---------------------------------------------------------------------------
// key_expansion_seq_if
//
// Bundles the start request and the round-key output channel of the AES-128
// key-schedule engine.
//
//   i_Start     start request (only honoured while the engine is idle)
//   i_Key       128-bit cipher key, w0 = [127:96] .. w3 = [31:0]
//   i_Ready     consumer ready for o_RoundKey
//   o_RoundKey  current round key
//   o_Round     index of o_RoundKey, 0..10
//   o_Valid     o_RoundKey / o_Round valid
//   o_Busy      engine not idle
//   o_Done      one-cycle pulse after round 10 has been accepted
//
// Handshake: a round key transfers on a rising clock edge where
// o_Valid & i_Ready are both high. Once o_Valid is raised, o_RoundKey and
// o_Round stay stable and o_Valid stays high until that transfer; i_Ready may
// toggle freely and never feeds back into the key datapath.
//
// Modports:
//   slave  - the key-schedule engine
//   master - the requester / round-key consumer
// ---------------------------------------------------------------------------
interface key_expansion_seq_if;
  logic         i_Start;
  logic [127:0] i_Key;
  logic         i_Ready;
  logic [127:0] o_RoundKey;
  logic [3:0]   o_Round;
  logic         o_Valid;
  logic         o_Busy;
  logic         o_Done;

  modport slave (
    input  i_Start, i_Key, i_Ready,
    output o_RoundKey, o_Round, o_Valid, o_Busy, o_Done
  );

  modport master (
    output i_Start, i_Key, i_Ready,
    input  o_RoundKey, o_Round, o_Valid, o_Busy, o_Done
  );
endinterface

// File: rtl/key_expansion_seq.sv
// ---------------------------------------------------------------------------
// key_expansion_seq
//
// Sequential AES-128 key schedule. Latches a cipher key on start and hands
// out round keys 0..10 one per valid/ready transfer. Each new round key is
// built from the previous one with a single shared g-function
// (RotWord, SubWord, Rcon on the MSB byte).
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst        asynchronous, active-high reset
//   bus          key_expansion_seq_if.slave (start/key in, round keys out)
//   o_dbg_state  current FSM state (IDLE=0, PRESENT=1, EXPAND=2, FINISH=3)
//
// Parameters:
//   NUM_ROUNDS   number of expansion rounds; only 10 (AES-128) is meaningful
//   ZEROIZE      1: clear the key register when returning to IDLE after the
//                last round key is accepted; 0: keep the last round key
// ---------------------------------------------------------------------------

// g-function: RotWord, SubWord, then XOR the round constant into the MSB byte.
module g_function (
  input  logic [31:0] i_word,
  input  logic [3:0]  i_round,
  output logic [31:0] o_word
);
  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at packed index 255-x, which for 8 bits is ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  // Round constants for rounds 1..10; other indices never reach EXPAND.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [31:0] rot_word;

  always_comb begin
    rot_word = {i_word[23:0], i_word[31:24]};
    o_word   = {sbox(rot_word[31:24]) ^ rcon(i_round),
                sbox(rot_word[23:16]),
                sbox(rot_word[15:8]),
                sbox(rot_word[7:0])};
  end
endmodule

module key_expansion_seq #(
  parameter int NUM_ROUNDS = 10,
  parameter bit ZEROIZE    = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  key_expansion_seq_if.slave    bus,
  output logic [1:0]            o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_EXPAND  = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t       state_q, state_d;
  logic [127:0] key_q,   key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;

  logic [3:0]   g_round;
  logic [31:0]  g_word;
  logic [31:0]  n0, n1, n2, n3;

  // The g-function only sees the registered key and round, so i_Ready never
  // reaches the S-box; its result is captured into key_q during EXPAND.
  assign g_round = round_q + 4'd1;

  g_function u_g_function (
    .i_word  (key_q[31:0]),
    .i_round (g_round),
    .o_word  (g_word)
  );

  always_comb begin
    n0 = key_q[127:96] ^ g_word;
    n1 = key_q[95:64]  ^ n0;
    n2 = key_q[63:32]  ^ n1;
    n3 = key_q[31:0]   ^ n2;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.i_Start) begin
          key_d   = bus.i_Key;
          round_d = 4'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_PRESENT;
        end
      end

      S_PRESENT: begin
        // valid_q is high throughout PRESENT, so i_Ready alone marks a transfer.
        if (bus.i_Ready) begin
          valid_d = 1'b0;
          if (round_q == LAST_ROUND) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_EXPAND;
          end
        end
      end

      S_EXPAND: begin
        key_d   = {n0, n1, n2, n3};
        round_d = round_q + 4'd1;
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (ZEROIZE) key_d = '0;
      end

      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_RoundKey = key_q;
  assign bus.o_Round    = round_q;
  assign bus.o_Valid    = valid_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Done     = done_q;
  assign o_dbg_state    = state_q;
endmodule
